// File: rtl/ad7606_sample_sched_if.sv
// Sample stream carrying one AD7606 channel word per transfer.
// Latency: n/a (wires only).
// Backpressure: valid/ready; the master holds its word until ready is seen.
interface ad7606_sample_sched_if;
    logic        smp_valid;
    logic        smp_ready;
    logic [15:0] smp_data;
    logic [2:0]  smp_chan;
    logic        smp_last;

    modport master (
        output smp_valid,
        output smp_data,
        output smp_chan,
        output smp_last,
        input  smp_ready
    );

    modport slave (
        input  smp_valid,
        input  smp_data,
        input  smp_chan,
        input  smp_last,
        output smp_ready
    );
endinterface

// File: rtl/ad7606_sample_sched.sv
// Periodic AD7606 conversion scheduler and enabled-channel serializer.
// Latency: conv_start one cycle after tick; first word the cycle after conv_done.
// Backpressure: word held while smp_ready low; ticks during a frame count as overruns.
module ad7606_sample_sched #(
    parameter int PER_W   = 16,
    parameter int TMO_CYC = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [PER_W-1:0]      period,
    input  logic [7:0]            ch_mask,
    output logic                  conv_start,
    input  logic                  conv_done,
    input  logic [127:0]          ch_data,
    ad7606_sample_sched_if.master smp,
    output logic                  busy,
    output logic [7:0]            overrun_cnt,
    output logic                  timeout
);
    localparam int TMO_W = (TMO_CYC < 2) ? 1 : $clog2(TMO_CYC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    function automatic logic [2:0] low_bit(input logic [7:0] m);
        low_bit = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) low_bit = i[2:0];
        end
    endfunction

    state_t             state_q, state_d;
    logic [PER_W-1:0]   pc_q, pc_d;
    logic [PER_W-1:0]   per_q, per_d;
    logic               en_q, en_d;
    logic [7:0]         mask_q, mask_d;
    logic [2:0]         idx_q, idx_d;
    logic [127:0]       shadow_q, shadow_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [7:0]         ovr_q, ovr_d;
    logic               tmo_flag_q, tmo_flag_d;
    logic               start_q, start_d;

    logic [PER_W-1:0]   per_min;
    logic               tick;
    logic [7:0]         above;
    logic               in_stream;
    logic               is_last;

    always_comb begin
        per_min   = (period < PER_W'(2)) ? PER_W'(2) : period;
        tick      = enable && (pc_q == per_q - PER_W'(1));
        above     = mask_q & (8'hFE << idx_q);
        is_last   = (above == 8'd0);
        in_stream = (state_q == S_STREAM);
    end

    // Stream outputs decode straight from the state so an async reset clears them at once.
    assign smp.smp_valid = in_stream;
    assign smp.smp_data  = in_stream ? shadow_q[{idx_q, 4'b0000} +: 16] : 16'd0;
    assign smp.smp_chan  = in_stream ? idx_q : 3'd0;
    assign smp.smp_last  = in_stream && is_last;
    assign busy          = (state_q != S_IDLE);
    assign conv_start    = start_q;
    assign overrun_cnt   = ovr_q;
    assign timeout       = tmo_flag_q;

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        idx_d      = idx_q;
        shadow_d   = shadow_q;
        tmo_d      = tmo_q;
        ovr_d      = ovr_q;
        tmo_flag_d = tmo_flag_q;
        start_d    = 1'b0;
        en_d       = enable;
        pc_d       = (!enable || tick) ? '0 : pc_q + PER_W'(1);
        // New period applies from the next period boundary, or when sampling starts.
        per_d      = ((enable && !en_q) || tick) ? per_min : per_q;

        if (tick && (state_q != S_IDLE) && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (tick) begin
                    start_d = 1'b1;
                    mask_d  = ch_mask;
                    tmo_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (conv_done) begin
                    shadow_d = ch_data;
                    if (mask_q != 8'd0) begin
                        idx_d   = low_bit(mask_q);
                        state_d = S_STREAM;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                    tmo_flag_d = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_STREAM: begin
                if (smp.smp_ready) begin
                    if (is_last) state_d = S_IDLE;
                    else         idx_d   = low_bit(above);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            per_q      <= PER_W'(2);
            en_q       <= 1'b0;
            mask_q     <= 8'd0;
            idx_q      <= 3'd0;
            shadow_q   <= 128'd0;
            tmo_q      <= '0;
            ovr_q      <= 8'd0;
            tmo_flag_q <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            per_q      <= per_d;
            en_q       <= en_d;
            mask_q     <= mask_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            tmo_q      <= tmo_d;
            ovr_q      <= ovr_d;
            tmo_flag_q <= tmo_flag_d;
            start_q    <= start_d;
        end
    end
endmodule

// File: tb/tb_ad7606_sample_sched.sv
// Scoreboard bench for ad7606_sample_sched with a capture-core model and directed timing checks.
module tb_ad7606_sample_sched;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [15:0]  period = 16'd100;
    logic [7:0]   ch_mask = 8'hFF;
    logic         conv_start;
    logic         conv_done = 1'b0;
    logic [127:0] ch_data = '0;
    logic         busy;
    logic [7:0]   overrun_cnt;
    logic         timeout;

    ad7606_sample_sched_if sif();

    ad7606_sample_sched #(.PER_W(16), .TMO_CYC(1023)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .period      (period),
        .ch_mask     (ch_mask),
        .conv_start  (conv_start),
        .conv_done   (conv_done),
        .ch_data     (ch_data),
        .smp         (sif),
        .busy        (busy),
        .overrun_cnt (overrun_cnt),
        .timeout     (timeout)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int starts[$];
    logic [19:0] exp_q[$];
    int valid_cycles = 0;
    int xfer_cnt = 0;
    int pushed_cnt = 0;
    logic [7:0] mask_edge = 8'h00;
    bit respond = 1'b1;
    bit fixed_data = 1'b1;
    bit dly_rand = 1'b0;
    int dly = 40;
    bit model_busy = 1'b0;

    initial forever #10 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end
    initial forever begin @(posedge clk); mask_edge = ch_mask; end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Capture-core model: answers each conv_start and pushes the words the frame must produce.
    initial begin
        logic [7:0]  m;
        logic [15:0] w[8];
        int d, hi;
        forever begin
            @(negedge clk);
            if (rst_n && conv_start && respond) begin
                model_busy = 1'b1;
                m = mask_edge;
                d = dly_rand ? int'($urandom_range(5, 30)) : dly;
                repeat (d) @(posedge clk);
                #1;
                hi = -1;
                for (int k = 0; k < 8; k++) begin
                    w[k] = fixed_data ? 16'h1000 + 16'(k) : 16'($urandom);
                    ch_data[16*k +: 16] = w[k];
                    if (m[k]) hi = k;
                end
                for (int k = 0; k < 8; k++) begin
                    if (m[k]) begin
                        exp_q.push_back({w[k], 3'(k), 1'(k == hi)});
                        pushed_cnt++;
                    end
                end
                conv_done = 1'b1;
                @(posedge clk);
                #1 conv_done = 1'b0;
                model_busy = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst_n && conv_start) starts.push_back(cyc);
    end

    // Monitor: every valid cycle must show the queue head; it pops on transfer.
    initial begin
        bit stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) chk("valid_held", sif.smp_valid, 1);
                if (sif.smp_valid) begin
                    valid_cycles++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_word: got chan %0d data %0h expected none",
                                 sif.smp_chan, sif.smp_data);
                    end else begin
                        chk("word{data,chan,last}", {sif.smp_data, sif.smp_chan, sif.smp_last}, exp_q[0]);
                        if (sif.smp_ready) begin
                            void'(exp_q.pop_front());
                            xfer_cnt++;
                        end
                    end
                end
                stall_prev = sif.smp_valid && !sif.smp_ready;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_conv_start"}, conv_start, 0);
        chk({tag, "_smp_valid"}, sif.smp_valid, 0);
        chk({tag, "_smp_data"}, sif.smp_data, 0);
        chk({tag, "_smp_chan"}, sif.smp_chan, 0);
        chk({tag, "_smp_last"}, sif.smp_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overrun"}, overrun_cnt, 0);
        chk({tag, "_timeout"}, timeout, 0);
    endtask

    task automatic do_reset(input string tag);
        int b = 0;
        enable = 1'b0;
        while (model_busy && b < 200) begin @(posedge clk); b++; end
        if (model_busy) fail_now({tag, "_model_idle"});
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 chk_reset_outputs(tag);
        rst_n = 1'b1;
        starts.delete();
        valid_cycles = 0;
        xfer_cnt = 0;
        pushed_cnt = 0;
    endtask

    task automatic wait_starts(input int n, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #2;
            if (starts.size() >= n) return;
        end
        fail_now(nm);
    endtask

    task automatic goto_neg(input int c);
        do begin @(posedge clk); #1; end while (cyc < c);
        @(negedge clk);
    endtask

    task automatic wait_valid(input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sif.smp_valid) return;
        end
        fail_now(nm);
    endtask

    initial begin
        int s0, cr, lst, m;
        sif.smp_ready = 1'b1;

        // Basic periodic sampling, full mask.
        do_reset("rst0");
        period = 16'd100; ch_mask = 8'hFF; dly = 40; fixed_data = 1'b1;
        enable = 1'b1;
        wait_starts(3, 400, "basic_starts");
        repeat (60) @(posedge clk);
        #1 enable = 1'b0;
        repeat (10) @(posedge clk);
        if (starts.size() >= 3) begin
            chk("basic_spacing1", starts[1] - starts[0], 100);
            chk("basic_spacing2", starts[2] - starts[1], 100);
        end
        chk("basic_valid_cycles", valid_cycles, 24);
        chk("basic_xfers", xfer_cnt, 24);
        chk("basic_overrun", overrun_cnt, 0);

        // Sparse mask with ready toggling every cycle.
        do_reset("rst1");
        period = 16'd50; ch_mask = 8'b1010_0100; dly = 10; fixed_data = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 150; i++) begin
            @(posedge clk);
            #1 sif.smp_ready = ~sif.smp_ready;
            if (i == 130) enable = 1'b0;
        end
        sif.smp_ready = 1'b1;
        chk("sparse_starts", starts.size(), 2);
        chk("sparse_xfers", xfer_cnt, 6);
        chk("sparse_overrun", overrun_cnt, 0);

        // Random masks changing every cycle, random ready and response delay.
        do_reset("rst2");
        period = 16'd60; dly_rand = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 800; i++) begin
            @(posedge clk);
            #1;
            ch_mask = 8'($urandom);
            sif.smp_ready = ($urandom_range(0, 3) != 0);
        end
        enable = 1'b0;
        sif.smp_ready = 1'b1;
        repeat (60) @(posedge clk);
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_xfers", xfer_cnt, pushed_cnt);
        chk("rand_busy", busy, 0);
        dly_rand = 1'b0;

        // Overrun while stalled, then resume on the first tick after drain.
        do_reset("rst3");
        period = 16'd20; ch_mask = 8'hFF; dly = 5; fixed_data = 1'b1;
        sif.smp_ready = 1'b0;
        enable = 1'b1;
        wait_starts(1, 100, "ovr_first_start");
        s0 = (starts.size() > 0) ? starts[0] : cyc;
        wait_valid(40, "ovr_valid");
        repeat (50) @(posedge clk);
        #1 sif.smp_ready = 1'b1;
        cr = cyc;
        lst = cr + 7;
        m = 1;
        while (s0 - 1 + 20 * m <= lst) m++;
        wait_starts(2, 200, "ovr_resume");
        if (starts.size() >= 2) chk("ovr_resume_cycle", starts[1], s0 + 20 * m);
        chk("ovr_count", overrun_cnt, m - 1);
        #1 enable = 1'b0;
        repeat (30) @(posedge clk);

        // Saturation with period 1 clamped to 2.
        do_reset("rst4");
        period = 16'd1; dly = 3;
        sif.smp_ready = 1'b0;
        enable = 1'b1;
        wait_starts(1, 20, "sat_start");
        s0 = (starts.size() > 0) ? starts[0] : cyc;
        goto_neg(s0 + 100);
        chk("sat_clamp_count", overrun_cnt, 50);
        chk("sat_no_restart", starts.size(), 1);
        repeat (600) @(posedge clk);
        #1 chk("sat_255", overrun_cnt, 255);

        // Timeout on a withheld conv_done.
        do_reset("rst5");
        sif.smp_ready = 1'b1;
        period = 16'd1100; respond = 1'b0; dly = 10;
        enable = 1'b1;
        wait_starts(1, 1300, "tmo_start");
        s0 = (starts.size() > 0) ? starts[0] : cyc;
        goto_neg(s0 + 1022);
        chk("tmo_before", timeout, 0);
        chk("tmo_busy_before", busy, 1);
        goto_neg(s0 + 1023);
        chk("tmo_set", timeout, 1);
        chk("tmo_idle", busy, 0);
        respond = 1'b1;
        wait_starts(2, 200, "tmo_next_start");
        if (starts.size() >= 2) chk("tmo_next_cycle", starts[1], s0 + 1100);
        #1 enable = 1'b0;
        repeat (40) @(posedge clk);
        chk("tmo_sticky", timeout, 1);
        chk("tmo_frame_xfers", xfer_cnt, 8);

        // Empty mask: conversions happen, nothing streams.
        do_reset("rst6");
        period = 16'd100; ch_mask = 8'h00;
        enable = 1'b1;
        wait_starts(2, 300, "empty_starts");
        repeat (30) @(posedge clk);
        #1 enable = 1'b0;
        if (starts.size() >= 2) chk("empty_spacing", starts[1] - starts[0], 100);
        chk("empty_valid_cycles", valid_cycles, 0);
        chk("empty_busy", busy, 0);

        // Reset during the third word of a frame.
        do_reset("rst7");
        ch_mask = 8'hFF;
        enable = 1'b1;
        wait_valid(200, "midrst_valid");
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        enable = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        valid_cycles = 0;
        starts.delete();
        repeat (150) @(posedge clk);
        chk("midrst_no_output", valid_cycles, 0);
        chk("midrst_no_start", starts.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ad7606_sample_sched.md
# ad7606_sample_sched

Conversion scheduler and channel serializer for the AD7606 capture core. It issues conversion-start pulses at a programmable period and waits for the core's frame-complete pulse. It then snapshots the eight channel results and streams the enabled channels one word at a time over a valid/ready interface to downstream logic (FIFO, UART packer). It also counts conversion requests lost to overrun and flags frames that never complete.

## Interface
- `PER_W`, default 16: width of the period register.
- `TMO_CYC`, default 1023: cycles allowed in WAIT_DONE before timeout.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous active-low reset.
- `enable`  in  1  level; 1 = periodic sampling on.
- `period`  in  PER_W  clocks between conversion starts; values below 2 are treated as 2.
- `ch_mask`  in  8  bit k = stream channel k+1.
- `conv_start`  out  1  one-cycle pulse; request one conversion and frame read from the capture core.
- `conv_done`  in  1  one-cycle pulse; the capture core has updated all eight channel registers.
- `ch_data`  in  128  packed channel results; [16k+15:16k] = channel k+1.
- `smp_valid`  out  1  stream word valid.
- `smp_ready`  in  1  downstream accepts the word.
- `smp_data`  out  16  sample value (two's complement, passed through).
- `smp_chan`  out  3  channel index 0..7.
- `smp_last`  out  1  last enabled channel of the frame.
- `busy`  out  1  high in WAIT_DONE or STREAM.
- `overrun_cnt`  out  8  dropped-tick counter; saturates at 255.
- `timeout`  out  1  sticky; cleared only by reset.

## Operation
- Period counter `pc`:
  - When `enable`=1, `pc` counts 0..P-1 and raises an internal `tick` in the cycle `pc`==P-1.
  - P is latched from `period` when `enable` rises and at every tick, so a changed value takes effect in the following period.
  - When `enable`=0, `pc` is held at 0 and no ticks occur. A frame already in progress completes normally.
- States:
  - IDLE: on `tick`, pulse `conv_start`, latch `ch_mask` into `mask_q`, clear the timeout counter, go to WAIT_DONE.
  - WAIT_DONE: on `conv_done`, load shadow[0..7] from `ch_data`.
    - If `mask_q`≠0: set `idx` to the lowest set bit and go to STREAM.
    - If `mask_q`=0: discard the frame and go to IDLE.
    - If no `conv_done` arrives within TMO_CYC cycles: set `timeout`, go to IDLE.
  - STREAM: outputs are combinational on the state: `smp_valid`=1, `smp_data`=shadow[idx], `smp_chan`=idx, `smp_last`=(no set bit of `mask_q` above idx).
    - On `smp_valid`&`smp_ready`: if `smp_last`, go to IDLE; otherwise `idx` moves to the next set bit.
- A `tick` in any state other than IDLE produces no `conv_start` and increments `overrun_cnt` (saturating at 255).
- A `tick` in the same cycle as the STREAM→IDLE transition also counts as an overrun. The next conversion starts on the following tick.
- `conv_done` outside WAIT_DONE is ignored.
- `ch_mask` changes take effect only at the next `conv_start`.

## Timing
- Reset values: `conv_start`=0, `smp_valid`=0, `smp_data`=0, `smp_chan`=0, `smp_last`=0, `busy`=0, `overrun_cnt`=0, `timeout`=0, state IDLE, `pc`=0.
- Asserting `rst_n` low mid-frame aborts the frame immediately. There is no partial output after release.
- `conv_start` is a registered output, high exactly one cycle, in the cycle after the `tick` cycle.
- `conv_done` sampled at edge E: shadow registers are loaded at E, and `smp_valid` is high from the cycle after E.
- With `smp_ready` held at 1, one word is transferred per cycle. N enabled channels occupy N cycles in STREAM.
- While `smp_valid`=1 and `smp_ready`=0, `smp_data`, `smp_chan` and `smp_last` are held stable. `smp_valid` never drops without a transfer.
- With `enable` continuously high, `conv_start` pulses are spaced exactly P cycles apart when no overrun occurs.
- Timeout is counted in cycles spent in WAIT_DONE. `timeout` is set in the cycle after the TMO_CYC-th cycle without `conv_done`.

## Test plan
- Basic periodic sampling: `period`=100, `enable`=1, `ch_mask`=8'hFF, `smp_ready`=1; model returns `conv_done` 40 cycles after each `conv_start` with channel k = 16'h1000+k.
  - Required: `conv_start` every 100 cycles.
  - Each frame streams 8 words in 8 consecutive cycles with `smp_chan` 0..7 and data 16'h1000..16'h1007.
  - `smp_last` is set only on channel 7; `overrun_cnt`=0.
- Sparse mask with backpressure: `ch_mask`=8'b1010_0100, `smp_ready` toggling 0/1.
  - Required: words are channels 2, 5, 7, in that order; `smp_last` only on channel 7.
  - Outputs are stable during every ready-low cycle.
- Overrun: `period`=20, `smp_ready`=0 for 50 cycles after the first frame.
  - Required: `overrun_cnt` increments once per tick while the frame is stalled, and no `conv_start` is issued.
  - Sampling resumes on the first tick after the frame drains.
  - Separately, force 300 stalled ticks; `overrun_cnt` must saturate at 255.
- Timeout and empty mask:
  - Withhold `conv_done`: `timeout` rises after 1023 cycles, the state returns to IDLE, and the next tick issues `conv_start`.
  - With `ch_mask`=0: `conv_start` still occurs, `conv_done` returns the block to IDLE, and `smp_valid` never asserts.
- Reset mid-stream and mask change:
  - Drop `rst_n` low during the third word of a frame: every output immediately takes its reset value.
  - Change `ch_mask` mid-frame: the current frame uses the old mask, and the next frame uses the new one.
